// File: rtl/fast_pkg.sv
// ---------------------------------------------------------------------------
// fast_pkg
// Shared definitions for the corner packer: word tags, field offsets of the
// packed 32-bit words, the packer FSM state type and the word builders.
//   Corner word : {2'b01, y[29:20], x[19:10], 10'b0}
//   Trailer word: {2'b10, ovf[29], trunc[28], dropped[27:16], count[15:0]}
// ---------------------------------------------------------------------------
package fast_pkg;

    localparam logic [1:0] TAG_CORNER  = 2'b01;
    localparam logic [1:0] TAG_TRAILER = 2'b10;

    localparam int TAG_LSB       = 30;
    localparam int CORNER_Y_LSB  = 20;
    localparam int CORNER_X_LSB  = 10;
    localparam int TRL_OVF_BIT   = 29;
    localparam int TRL_TRUNC_BIT = 28;
    localparam int TRL_DROP_LSB  = 16;
    localparam int TRL_COUNT_LSB = 0;

    localparam logic [11:0] DROP_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        TRAILER = 2'd2
    } cpk_state_t;

    function automatic logic [31:0] pack_corner(input logic [9:0] x, input logic [9:0] y);
        logic [31:0] w;
        w = '0;
        w[TAG_LSB +: 2]       = TAG_CORNER;
        w[CORNER_Y_LSB +: 10] = y;
        w[CORNER_X_LSB +: 10] = x;
        return w;
    endfunction

    function automatic logic [31:0] pack_trailer(input logic        ovf,
                                                 input logic        trunc,
                                                 input logic [11:0] dropped,
                                                 input logic [15:0] count);
        logic [31:0] w;
        w = '0;
        w[TAG_LSB +: 2]        = TAG_TRAILER;
        w[TRL_OVF_BIT]         = ovf;
        w[TRL_TRUNC_BIT]       = trunc;
        w[TRL_DROP_LSB +: 12]  = dropped;
        w[TRL_COUNT_LSB +: 16] = count;
        return w;
    endfunction

endpackage

// File: rtl/corner_fifo.sv
// ---------------------------------------------------------------------------
// corner_fifo
// Synchronous first-word-fall-through FIFO. Words live in an inferred RAM
// with registered read; the head word is held in an output register, so a
// word written at edge N is visible on dout_o/dout_valid_o after edge N+1.
// Total capacity (RAM + output register) is DEPTH words.
// Ports:
//   clk            clock
//   rst            synchronous reset, active-low
//   push_i         write push_data_i (ignored when full and not popping)
//   push_data_i    word to write
//   pop_i          consume the head word (only effective while dout_valid_o)
//   dout_o         head word, stable while not popped
//   dout_valid_o   dout_o holds a word
//   used_o         words held, including the output register
//   full_o/empty_o used_o == DEPTH / used_o == 0
// ---------------------------------------------------------------------------
module corner_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            dout_o,
    output logic                     dout_valid_o,
    output logic [$clog2(DEPTH):0]   used_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q;

    logic pop_ok;
    logic push_ok;
    logic load;
    logic [CW-1:0] used;

    assign used    = mem_cnt_q + CW'(out_valid_q);
    assign pop_ok  = pop_i & out_valid_q;
    // A pop frees a slot in the same cycle, so push+pop is legal even when full.
    assign push_ok = push_i & ((used != CW'(DEPTH)) | pop_ok);
    // Refill the output register whenever it is empty or being drained.
    assign load    = (mem_cnt_q != '0) & (~out_valid_q | pop_ok);

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        if (push_ok && !load) begin
            mem_cnt_d = mem_cnt_q + CW'(1);
        end else if (!push_ok && load) begin
            mem_cnt_d = mem_cnt_q - CW'(1);
        end

        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (pop_ok) begin
            out_valid_d = 1'b0;
        end
    end

    // RAM write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Registered read into the output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_q <= '0;
        end else if (load) begin
            out_data_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout_o       = out_data_q;
    assign dout_valid_o = out_valid_q;
    assign used_o       = used;
    assign full_o       = (used == CW'(DEPTH));
    assign empty_o      = (used == '0);

endmodule

// File: rtl/corner_packer.sv
// ---------------------------------------------------------------------------
// corner_packer
// Packs corner flags/coordinates from the NMS stage into 32-bit words, queues
// them in a FWFT FIFO and closes every frame with a trailer word carrying the
// corner count, drop count and overflow/truncation flags.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   ce                  input qualifier for sof/eof/iscorner
//   sof, eof            frame delimiters
//   iscorner            corner flag, with x_coord / y_coord
//   m_data, m_valid     output word stream
//   m_ready             consumer accepts the head word
//   m_last              head word is a trailer
//   frame_done          one-cycle pulse after a trailer is popped
//   busy                FSM not idle or FIFO not empty
// ---------------------------------------------------------------------------
module corner_packer
    import fast_pkg::*;
#(
    parameter int unsigned MAX_CORNERS = 1024,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned COORD_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               sof,
    input  logic               eof,
    input  logic               iscorner,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    output logic [31:0]        m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               frame_done,
    output logic               busy
);

    localparam int unsigned UW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW = $clog2(MAX_CORNERS + 1);

    cpk_state_t  state_q;
    logic [CW-1:0] count_q;
    logic [11:0] dropped_q;
    logic        ovf_q;
    logic        trunc_q;
    logic        restart_q;
    logic        frame_done_q;

    logic          corner_in, sof_in, eof_in;
    logic          room, under_cap;
    logic          corner_push;
    logic          fifo_push;
    logic [31:0]   fifo_wdata;
    logic          fifo_pop;
    logic [UW-1:0] fifo_used;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;
    logic          fifo_dvalid;

    assign corner_in = ce & iscorner;
    assign sof_in    = ce & sof;
    assign eof_in    = ce & eof;

    // One slot is always kept free for the trailer while collecting.
    assign room      = ~fifo_full & (fifo_used < UW'(FIFO_DEPTH - 1));
    assign under_cap = (count_q < CW'(MAX_CORNERS));

    always_comb begin
        corner_push = 1'b0;
        fifo_push   = 1'b0;
        fifo_wdata  = '0;
        case (state_q)
            COLLECT: begin
                if (corner_in && room && under_cap) begin
                    corner_push = 1'b1;
                    fifo_push   = 1'b1;
                    fifo_wdata  = pack_corner(10'(x_coord), 10'(y_coord));
                end
            end
            TRAILER: begin
                fifo_push  = 1'b1;
                fifo_wdata = pack_trailer(ovf_q, trunc_q, dropped_q, 16'(count_q));
            end
            default: begin
                fifo_push = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            dropped_q <= '0;
            ovf_q     <= 1'b0;
            trunc_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sof_in) begin
                        state_q   <= COLLECT;
                        count_q   <= '0;
                        dropped_q <= '0;
                        ovf_q     <= 1'b0;
                        trunc_q   <= 1'b0;
                        restart_q <= 1'b0;
                    end
                end
                COLLECT: begin
                    // The corner of this cycle is accounted before any eof/sof.
                    if (corner_in) begin
                        if (corner_push) begin
                            count_q <= count_q + CW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                            if (dropped_q != DROP_MAX) begin
                                dropped_q <= dropped_q + 12'd1;
                            end
                        end
                    end
                    if (eof_in) begin
                        // eof together with sof closes normally and reopens.
                        state_q   <= TRAILER;
                        trunc_q   <= 1'b0;
                        restart_q <= sof_in;
                    end else if (sof_in) begin
                        state_q   <= TRAILER;
                        trunc_q   <= 1'b1;
                        restart_q <= 1'b1;
                    end
                end
                TRAILER: begin
                    if (restart_q || sof_in) begin
                        // A corner in the trailer cycle belongs to the new frame
                        // and cannot be stored, so it opens the frame as a drop.
                        state_q   <= COLLECT;
                        count_q   <= '0;
                        dropped_q <= corner_in ? 12'd1 : 12'd0;
                        ovf_q     <= corner_in;
                        trunc_q   <= 1'b0;
                        restart_q <= 1'b0;
                    end else begin
                        state_q   <= IDLE;
                        restart_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    corner_fifo #(
        .DW    (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fifo_push),
        .push_data_i  (fifo_wdata),
        .pop_i        (fifo_pop),
        .dout_o       (fifo_dout),
        .dout_valid_o (fifo_dvalid),
        .used_o       (fifo_used),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign fifo_pop = fifo_dvalid & m_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= fifo_pop & m_last;
        end
    end

    assign m_data     = fifo_dout;
    assign m_valid    = fifo_dvalid;
    assign m_last     = fifo_dvalid & (fifo_dout[TAG_LSB +: 2] == TAG_TRAILER);
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE) | ~fifo_empty;

endmodule
